regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug readout engine that acts as the reader end of the processor register file. On a start pulse it walks every architectural register, drives the register file's combinational read address, snapshots each word, and streams it out byte-wise, least significant byte first, over a valid/ready byte channel toward the debug/UART bridge. It sits beside the register file on a dedicated third read port and never writes architectural state.

## Interface
Parameters:
- N, 32, register data width; must be a multiple of 8.
- NREGS, 32, number of registers dumped; must be ≤ 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  dump request; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after rst.
- busy  out  1  high in FETCH and SEND.
- done  out  1  one-cycle pulse after the last byte of a completed dump.
- rf_addr  out  5  read address to the register file port.
- rf_data  in  N  combinational read data for rf_addr.
- out_valid  out  1  byte available.
- out_ready  in  1  consumer accepts byte.
- out_data  out  8  byte payload.
- out_last  out  1  high with the final byte of register NREGS-1.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE: on start=1 → FETCH, with addr=0.
- FETCH lasts exactly one cycle. rf_addr=addr. At the closing edge, rf_data is latched into an N-bit shift register and byte_cnt is set to 0. Next state is SEND.
- SEND:
  - out_valid=1 and out_data=shift[7:0].
  - On out_valid & out_ready with byte_cnt < N/8-1: shift right by 8 and increment byte_cnt.
  - On a handshake of the last byte with addr < NREGS-1: increment addr and go to FETCH.
  - On a handshake of the last byte with addr = NREGS-1: go to DONE.
- DONE: done=1 for one cycle, then IDLE. addr returns to 0.
- out_last = (state==SEND) & (addr==NREGS-1) & (byte_cnt==N/8-1).
- Each word is a per-register snapshot taken at its FETCH edge. Register file writes after that edge are not reflected in the word. Writes to registers not yet fetched are reflected.
- rf_addr is driven from the addr register, so it is glitch-free. It holds the value last used outside FETCH.
- start is ignored in FETCH, SEND and DONE. It does not queue.
- abort=1 in any state → IDLE at the next edge. out_valid drops and addr clears. No done pulse is produced.
  - Abort mid-byte with out_valid high is the only permitted valid withdrawal; the consumer discards the partial stream.
- x0 is dumped like every other register. The register file reads it as 0.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_last=0, rf_addr=0. State is IDLE and the shift register is 0.
- Start latency: start sampled at edge k gives FETCH in cycle k+1 and the first byte valid in cycle k+2.
- With out_ready held at 1, each register takes 1 + N/8 cycles. For N=32 and NREGS=32:
  - The final handshake is in cycle k+160.
  - done=1 in cycle k+161.
  - IDLE is reached in cycle k+162.
- While out_valid & !out_ready, out_data and out_last stay stable. Backpressure has unbounded length.
- Simultaneous start and abort in IDLE: abort wins and the state stays IDLE.
- rst asserted mid-dump: all outputs go to their reset values immediately. No done pulse is produced.

## Structure
- Package regfile_dump_pkg holds:
  - the state enum (IDLE, FETCH, SEND, DONE);
  - the BYTES_PER_REG = N/8 constant;
  - the byte-counter width, $clog2(BYTES_PER_REG) with a minimum of 1.
- One natural sub-module, word_serializer, owns:
  - the shift register and byte_cnt;
  - a load input and a byte-accept input;
  - a last_byte output.
- The top level keeps the FSM, the addr counter and the out_last/done decode.

## Test plan
- Reset and idle: preload RF[i]=0x11000000+i with x0=0 and out_ready=1, pulse start.
  - The first byte is 0x00 ×4 for x0; the next bytes are 0x01,0x00,0x00,0x11.
  - out_last fires only on the 128th byte; done pulses at k+161; busy falls at the same time.
- Backpressure: toggle out_ready with a pseudo-random 30% duty.
  - The 128-byte sequence matches the no-stall run.
  - out_data/out_last are stable during every stall.
  - No byte is duplicated or dropped.
- Snapshot rule: write RF[5]=0xDEADBEEF during SEND of register 5, and RF[9]=0xCAFEF00D while register 5 is sending.
  - The dump shows the old value for x5 and 0xCAFEF00D for x9.
- Abort: assert abort while sending byte 2 of register 17.
  - out_valid is 0 at the next cycle; no done; rf_addr=0.
  - A new start then dumps from x0.
- Async reset mid-dump: assert rst between edges during FETCH of register 20.
  - Outputs reach reset values before the next edge.
  - Start after release produces a full, correct dump.
- Ignored start: re-pulse start during SEND and during DONE.
  - Exactly one dump occurs; the byte count is 128; one done pulse.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg
// Shared types and sizing helpers for the register-file dump engine.
// Contents:
//   state_t        - FSM state encoding (IDLE, FETCH, SEND, DONE)
//   BYTES_PER_REG  - bytes per register word for the default 32-bit width
//   BYTE_CNT_W     - byte-counter width for the default width
//   bytes_per_reg  - bytes per word for an arbitrary width N
//   cnt_width      - byte-counter width, $clog2(bytes) but never below 1
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_N = 32;

  function automatic int bytes_per_reg(input int n);
    return n / 8;
  endfunction

  // A single-byte word would give $clog2(1) = 0; keep at least one bit.
  function automatic int cnt_width(input int bytes);
    return (bytes <= 2) ? 1 : $clog2(bytes);
  endfunction

  localparam int BYTES_PER_REG = bytes_per_reg(DEFAULT_N);
  localparam int BYTE_CNT_W    = cnt_width(BYTES_PER_REG);

endpackage

// File: rtl/regfile_dump_word_serializer.sv
// word_serializer
// Holds one register snapshot and presents it a byte at a time, LSB first.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset (clears word and count)
//   i_load       in   capture i_data and restart at byte 0
//   i_data       in   N-bit word to capture
//   i_accept     in   current byte consumed; advance unless it is the last
//   o_byte       out  current byte (low byte of the shift register)
//   o_last_byte  out  current byte is the final byte of the word
module word_serializer #(
  parameter int N     = 32,
  parameter int BYTES = N / 8,
  parameter int CW    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [N-1:0] i_data,
  input  logic         i_accept,
  output logic [7:0]   o_byte,
  output logic         o_last_byte
);

  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

  logic [N-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last      = (r_cnt == LAST_CNT);
  assign o_byte      = r_shift[7:0];
  assign o_last_byte = w_last;

  // The last byte is never shifted out: the word stays put until the next
  // load, so the byte on the channel cannot change under a stalled consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_accept && !w_last) begin
      r_shift <= r_shift >> 8;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// regfile_dump
// Debug readout engine on a dedicated read port of the register file. A start
// pulse walks registers 0..NREGS-1; each is snapshotted in a one-cycle FETCH
// and streamed LSB first over a valid/ready byte channel.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   dump request, honoured only in IDLE
//   abort      in   synchronous cancel back to IDLE (no done pulse)
//   busy       out  high in FETCH and SEND
//   done       out  one-cycle pulse after the final byte of a full dump
//   rf_addr    out  register-file read address (registered, glitch-free)
//   rf_data    in   combinational read data for rf_addr
//   out_valid  out  byte available
//   out_ready  in   consumer accepts byte
//   out_data   out  byte payload
//   out_last   out  final byte of register NREGS-1
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int N     = 32,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [4:0]   rf_addr,
  input  logic [N-1:0] rf_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last
);

  localparam int            BYTES     = bytes_per_reg(N);
  localparam int            CW        = cnt_width(BYTES);
  localparam logic [4:0]    LAST_ADDR = 5'(NREGS - 1);

  state_t     r_state;
  logic [4:0] r_addr;

  logic       w_fetch;
  logic       w_send;
  logic       w_hs;
  logic       w_last_byte;
  logic [7:0] w_byte;

  assign w_fetch = (r_state == ST_FETCH);
  assign w_send  = (r_state == ST_SEND);
  assign w_hs    = w_send & out_ready;

  word_serializer #(
    .N     (N),
    .BYTES (BYTES),
    .CW    (CW)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_fetch & ~abort),
    .i_data      (rf_data),
    .i_accept    (w_hs & ~abort),
    .o_byte      (w_byte),
    .o_last_byte (w_last_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_addr  <= '0;
          end
        end
        ST_FETCH: begin
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_hs && w_last_byte) begin
            if (r_addr == LAST_ADDR) begin
              r_state <= ST_DONE;
            end else begin
              r_addr  <= r_addr + 5'd1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_addr  <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_addr  <= '0;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // forces them to their idle values without waiting for a clock edge.
  assign busy      = w_fetch | w_send;
  assign done      = (r_state == ST_DONE);
  assign rf_addr   = r_addr;
  assign out_valid = w_send;
  assign out_data  = w_send ? w_byte : 8'h00;
  assign out_last  = w_send & (r_addr == LAST_ADDR) & w_last_byte;

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump
// Scenario bench for regfile_dump (N=32, NREGS=32). Expected bytes are pushed
// into a queue from the bench's own register-file model when a dump is
// started; a monitor pops and compares them on every handshake.
module tb_regfile_dump;

  localparam int N     = 32;
  localparam int NREGS = 32;
  localparam int BPR   = N / 8;
  localparam int TOTAL = NREGS * BPR;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic         busy;
  logic         done;
  logic [4:0]   rf_addr;
  logic [N-1:0] rf_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;

  logic [N-1:0] rf_mem [NREGS];
  assign rf_data = rf_mem[rf_addr];

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q [$];
  int bytes_seen = 0;
  int last_seen  = 0;
  int done_seen  = 0;

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_l = 1'b0;
  logic [8:0] mon_exp;

  regfile_dump #(.N(N), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Monitor: inputs change just after rising edges, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (done) done_seen++;
      if (prev_v && !prev_r && out_valid) begin
        n_tests++;
        if ({out_last, out_data} !== {prev_l, prev_d}) begin
          n_fail++;
          $display("FAIL stall_stable: got last=%b data=%02h, required last=%b data=%02h",
                   out_last, out_data, prev_l, prev_d);
        end
      end
      if (out_valid && out_ready) begin
        bytes_seen++;
        if (out_last) last_seen++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_byte: got last=%b data=%02h, required no byte", out_last, out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({out_last, out_data} !== mon_exp) begin
            n_fail++;
            $display("FAIL byte[%0d]: got last=%b data=%02h, required last=%b data=%02h",
                     bytes_seen - 1, out_last, out_data, mon_exp[8], mon_exp[7:0]);
          end
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_rf();
    for (int i = 0; i < NREGS; i++) rf_mem[i] = 32'h1100_0000 + 32'(i);
    rf_mem[0] = '0;
  endtask

  task automatic push_dump();
    for (int r = 0; r < NREGS; r++)
      for (int b = 0; b < BPR; b++)
        exp_q.push_back({(r == NREGS - 1) && (b == BPR - 1), rf_mem[r][8*b +: 8]});
  endtask

  task automatic clear_counts();
    bytes_seen = 0;
    last_seen  = 0;
    done_seen  = 0;
  endtask

  // Called just after a rising edge; returns one cycle after start is sampled.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int bound, input bit rnd, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (rnd) out_ready = ($urandom_range(0, 99) < 30);
      else     out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    init_rf();
    tick(); tick();
    n_tests++;
    if ({busy, done, out_valid, out_last, out_data, rf_addr} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b last=%b data=%02h addr=%0d, required all 0",
               busy, done, out_valid, out_last, out_data, rf_addr);
    end
    rst = 1'b0;
    tick(); tick();
    n_tests++;
    if ({busy, done, out_valid, out_last, out_data, rf_addr} !== 18'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: got busy=%b done=%b valid=%b addr=%0d, required all 0",
               busy, done, out_valid, rf_addr);
    end
  endtask

  task automatic test_basic();
    int done_rel = -1;
    int busy_fall_rel = -1;
    $display("[TB] basic dump, out_ready held high");
    clear_counts();
    push_dump();
    out_ready = 1'b1;
    pulse_start();
    n_tests++;
    if (!(busy === 1'b1 && out_valid === 1'b0 && rf_addr === 5'd0)) begin
      n_fail++;
      $display("FAIL fetch_cycle: got busy=%b valid=%b addr=%0d, required busy=1 valid=0 addr=0",
               busy, out_valid, rf_addr);
    end
    for (int rel = 1; rel <= 162; rel++) begin
      if (rel == 2) begin
        n_tests++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL first_byte_latency: got valid=%b at k+2, required 1", out_valid);
        end
      end
      if (done === 1'b1 && done_rel < 0) done_rel = rel;
      if (busy === 1'b0 && busy_fall_rel < 0) busy_fall_rel = rel;
      if (rel == 162) begin
        n_tests++;
        if ({busy, done, out_valid} !== 3'b000) begin
          n_fail++;
          $display("FAIL idle_at_k162: got busy=%b done=%b valid=%b, required 000", busy, done, out_valid);
        end
      end else begin
        tick();
      end
    end
    n_tests++;
    if (done_rel !== 161) begin
      n_fail++;
      $display("FAIL done_cycle: got k+%0d, required k+161", done_rel);
    end
    n_tests++;
    if (busy_fall_rel !== 161) begin
      n_fail++;
      $display("FAIL busy_fall_cycle: got k+%0d, required k+161", busy_fall_rel);
    end
    n_tests++;
    if (bytes_seen !== TOTAL || last_seen !== 1 || done_seen !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL basic_counts: got bytes=%0d last=%0d done=%0d left=%0d, required %0d 1 1 0",
               bytes_seen, last_seen, done_seen, exp_q.size(), TOTAL);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit seen;
    $display("[TB] dump with 30%% out_ready duty");
    clear_counts();
    push_dump();
    pulse_start();
    run_until_done(3000, 1'b1, seen);
    tick(); tick();
    n_tests++;
    if (!seen || bytes_seen !== TOTAL || last_seen !== 1 || done_seen !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL backpressure_counts: got done_seen=%b bytes=%0d last=%0d dones=%0d left=%0d, required 1 %0d 1 1 0",
               seen, bytes_seen, last_seen, done_seen, exp_q.size(), TOTAL);
    end
    exp_q.delete();
  endtask

  task automatic test_snapshot();
    bit seen;
    bit found = 1'b0;
    logic [N-1:0] w9 = 32'hCAFE_F00D;
    $display("[TB] snapshot: write x5 while sending x5, x9 before its fetch");
    clear_counts();
    push_dump();
    for (int b = 0; b < BPR; b++) exp_q[9*BPR + b] = {1'b0, w9[8*b +: 8]};
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (rf_addr == 5'd5 && out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    rf_mem[5] = 32'hDEAD_BEEF;
    rf_mem[9] = w9;
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL snapshot_reach_x5: got no SEND of x5 within 200 cycles, required one");
    end
    run_until_done(500, 1'b0, seen);
    tick(); tick();
    n_tests++;
    if (!seen || bytes_seen !== TOTAL || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL snapshot_counts: got done=%b bytes=%0d left=%0d, required 1 %0d 0",
               seen, bytes_seen, exp_q.size(), TOTAL);
    end
    exp_q.delete();
    rf_mem[5] = 32'h1100_0005;
    rf_mem[9] = 32'h1100_0009;
  endtask

  task automatic test_abort();
    bit seen;
    bit found = 1'b0;
    $display("[TB] abort during byte 2 of x17, then restart");
    clear_counts();
    push_dump();
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (bytes_seen == 17*BPR + 2 && out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!found || rf_addr !== 5'd17) begin
      n_fail++;
      $display("FAIL abort_reach: got found=%b addr=%0d, required 1 and 17", found, rf_addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    n_tests++;
    if ({out_valid, busy, done, rf_addr} !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_next_cycle: got valid=%b busy=%b done=%b addr=%0d, required all 0",
               out_valid, busy, done, rf_addr);
    end
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (done_seen !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b, required 0 0", done_seen, busy);
    end
    clear_counts();
    push_dump();
    pulse_start();
    run_until_done(500, 1'b0, seen);
    tick(); tick();
    n_tests++;
    if (!seen || bytes_seen !== TOTAL || done_seen !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL abort_restart: got done=%b bytes=%0d dones=%0d left=%0d, required 1 %0d 1 0",
               seen, bytes_seen, done_seen, exp_q.size(), TOTAL);
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    bit seen;
    bit found = 1'b0;
    $display("[TB] async reset during FETCH of x20, then full dump");
    clear_counts();
    push_dump();
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (rf_addr == 5'd20 && busy && !out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_reach_fetch20: got no FETCH of x20 within 500 cycles, required one");
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, out_valid, out_last, out_data, rf_addr} !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got busy=%b done=%b valid=%b last=%b data=%02h addr=%0d, required all 0",
               busy, done, out_valid, out_last, out_data, rf_addr);
    end
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got dones=%0d, required 0", done_seen);
    end
    clear_counts();
    push_dump();
    pulse_start();
    run_until_done(500, 1'b0, seen);
    tick(); tick();
    n_tests++;
    if (!seen || bytes_seen !== TOTAL || last_seen !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_restart: got done=%b bytes=%0d last=%0d left=%0d, required 1 %0d 1 0",
               seen, bytes_seen, last_seen, exp_q.size(), TOTAL);
    end
    exp_q.delete();
  endtask

  task automatic test_ignored_start();
    bit seen;
    bit busy_again = 1'b0;
    $display("[TB] start re-pulsed in SEND and DONE");
    clear_counts();
    push_dump();
    out_ready = 1'b1;
    pulse_start();
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(500, 1'b0, seen);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_again = 1'b1;
      tick();
    end
    n_tests++;
    if (!seen || busy_again || bytes_seen !== TOTAL || done_seen !== 1 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL ignored_start: got done=%b rebusy=%b bytes=%0d dones=%0d left=%0d, required 1 0 %0d 1 0",
               seen, busy_again, bytes_seen, done_seen, exp_q.size(), TOTAL);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_abort();
    test_async_reset();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
